window_seq_ctrl: RTL and testbench

Run controller for the sliding-window averager. It clears the window, then fetches N_SAMPLES values from an external sample table at a programmable tick rate and presents them as single-cycle `in_valid` beats. It counts and captures the averager's outputs and signals completion. It sits between the board-level top (start/pause/abort, LEDs) and the averager instance, replacing the free-running tick/ROM glue.

---
 rtl/window_seq_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_window_seq_ctrl.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/window_seq_ctrl.sv
// window_seq_ctrl: run controller for the sliding-window averager.
// A run clears the averager, then reads N_SAMPLES values from an external
// combinational sample table, one every DIV cycles. Each value goes out as a
// one-cycle in_valid beat. The controller counts and captures the averager
// outputs and reports completion with a done pulse. If the averager does not
// produce enough outputs in time, the run ends with timeout set.
//
// Ports:
//   clk, rst    clock; synchronous active-high reset
//   start       pulse, begins a run from IDLE
//   pause       level, freezes the sample tick counter while running
//   abort       pulse, terminates any run in progress
//   rom_addr    sample-table address
//   rom_data    sample-table data for rom_addr, same cycle
//   win_rst     synchronous clear to the averager
//   in_valid    registered one-cycle sample strobe
//   in_sample   registered sample value, held between strobes
//   out_valid   averager output strobe
//   out_avg     averager output value
//   avg_hold    last captured out_avg
//   out_count   averager outputs seen this run (saturating)
//   busy        high while clearing, running or draining
//   done        one-cycle pulse when a run completes
//   timeout     sticky drain-timeout flag, cleared by the next start
module window_seq_ctrl #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned L         = 4,
  parameter int unsigned N_SAMPLES = 7,
  parameter int unsigned IDX_W     = 3,
  parameter int unsigned DIV       = 100_000_000,
  parameter int unsigned DRAIN_MAX = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             pause,
  input  logic             abort,
  output logic [IDX_W-1:0] rom_addr,
  input  logic [WIDTH-1:0] rom_data,
  output logic             win_rst,
  output logic             in_valid,
  output logic [WIDTH-1:0] in_sample,
  input  logic             out_valid,
  input  logic [WIDTH-1:0] out_avg,
  output logic [WIDTH-1:0] avg_hold,
  output logic [7:0]       out_count,
  output logic             busy,
  output logic             done,
  output logic             timeout
);

  localparam int unsigned CntW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned DcntW = $clog2(DRAIN_MAX + 1);
  localparam int unsigned Exp   = N_SAMPLES - L + 1;

  localparam logic [CntW-1:0]  CntMax  = CntW'(DIV - 1);
  localparam logic [IDX_W:0]   LastIdx = (IDX_W + 1)'(N_SAMPLES - 1);
  localparam logic [DcntW-1:0] DcntMax = DcntW'(DRAIN_MAX);

  typedef enum logic [2:0] {StIdle, StClear, StRun, StDrain, StDone} state_e;

  state_e state_q, state_d;
  logic   clr_q, clr_d;      // set during the second CLEAR cycle
  logic   abort_q;           // an abort was taken last cycle

  logic [CntW-1:0]  cnt_q, cnt_d;
  // One bit wider than the table address, so idx can reach N_SAMPLES = 2^IDX_W without wrapping.
  logic [IDX_W:0]   idx_q, idx_d;
  logic [DcntW-1:0] dcnt_q, dcnt_d;
  logic             in_valid_q, in_valid_d;
  logic [WIDTH-1:0] in_sample_q, in_sample_d;
  logic [WIDTH-1:0] avg_hold_q, avg_hold_d;
  logic [7:0]       out_count_q, out_count_d;
  logic             timeout_q, timeout_d;

  logic run_abort, issue, drain_ok, drain_to;

  assign run_abort = abort & ((state_q == StClear) | (state_q == StRun) | (state_q == StDrain));
  // An abort in the same cycle suppresses the issue, so no strobe follows an abort.
  assign issue     = (state_q == StRun) & ~pause & ~abort & (cnt_q == CntMax);
  assign drain_ok  = ({24'd0, out_count_q} >= 32'(Exp));
  assign drain_to  = (dcnt_q == DcntMax);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      clr_q   <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
      abort_q <= run_abort;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (start && !abort) state_d = StClear;
      StClear: if (clr_q) state_d = StRun;
      StRun:   if (issue && (idx_q == LastIdx)) state_d = StDrain;
      StDrain: if (drain_ok || drain_to) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (run_abort) state_d = StIdle;
    clr_d = (state_q == StClear) && (state_d == StClear);
  end

  // FSM outputs
  always_comb begin
    busy    = (state_q == StClear) | (state_q == StRun) | (state_q == StDrain);
    done    = (state_q == StDone);
    win_rst = (state_q == StClear) | abort_q;
  end

  // Datapath next-state
  always_comb begin
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    dcnt_d      = '0;
    in_valid_d  = 1'b0;
    in_sample_d = in_sample_q;
    avg_hold_d  = avg_hold_q;
    out_count_d = out_count_q;
    timeout_d   = timeout_q;

    if (busy && out_valid) begin
      avg_hold_d = out_avg;
      if (out_count_q != 8'hFF) out_count_d = out_count_q + 8'd1;
    end

    case (state_q)
      StClear: begin
        cnt_d       = '0;
        idx_d       = '0;
        avg_hold_d  = '0;
        out_count_d = '0;
        timeout_d   = 1'b0;
      end
      StRun: begin
        if (!pause) cnt_d = (cnt_q == CntMax) ? '0 : cnt_q + CntW'(1);
        if (issue) begin
          in_valid_d  = 1'b1;
          in_sample_d = rom_data;
          idx_d       = idx_q + (IDX_W + 1)'(1);
        end
      end
      StDrain: begin
        dcnt_d = dcnt_q + DcntW'(1);
        if (!drain_ok && drain_to && !run_abort) timeout_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      idx_q       <= '0;
      dcnt_q      <= '0;
      in_valid_q  <= 1'b0;
      in_sample_q <= '0;
      avg_hold_q  <= '0;
      out_count_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      dcnt_q      <= dcnt_d;
      in_valid_q  <= in_valid_d;
      in_sample_q <= in_sample_d;
      avg_hold_q  <= avg_hold_d;
      out_count_q <= out_count_d;
      timeout_q   <= timeout_d;
    end
  end

  assign rom_addr  = idx_q[IDX_W-1:0];
  assign in_valid  = in_valid_q;
  assign in_sample = in_sample_q;
  assign avg_hold  = avg_hold_q;
  assign out_count = out_count_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_window_seq_ctrl.sv
// Directed bench for window_seq_ctrl with DIV=4, N_SAMPLES=7, L=4, DRAIN_MAX=16.
// Sample table holds addr+2. A 4-tap averager stub answers each strobe from
// the 4th onward with (sum of last 4) >> 2.
module tb_window_seq_ctrl;

  localparam int unsigned WIDTH     = 32;
  localparam int unsigned DRAIN_MAX = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              pause = 1'b0;
  logic              abort = 1'b0;
  logic [2:0]        rom_addr;
  logic [WIDTH-1:0]  rom_data;
  logic              win_rst;
  logic              in_valid;
  logic [WIDTH-1:0]  in_sample;
  logic              out_valid;
  logic [WIDTH-1:0]  out_avg;
  logic [WIDTH-1:0]  avg_hold;
  logic [7:0]        out_count;
  logic              busy;
  logic              done;
  logic              timeout;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  logic avg_en = 1'b1;

  window_seq_ctrl #(
    .WIDTH    (WIDTH),
    .L        (4),
    .N_SAMPLES(7),
    .IDX_W    (3),
    .DIV      (4),
    .DRAIN_MAX(DRAIN_MAX)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .pause    (pause),
    .abort    (abort),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .win_rst  (win_rst),
    .in_valid (in_valid),
    .in_sample(in_sample),
    .out_valid(out_valid),
    .out_avg  (out_avg),
    .avg_hold (avg_hold),
    .out_count(out_count),
    .busy     (busy),
    .done     (done),
    .timeout  (timeout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign rom_data = 32'(rom_addr) + 32'd2;

  // Averager stub
  logic [WIDTH-1:0] h0, h1, h2;
  int               hcnt;
  always @(posedge clk) begin
    if (rst || win_rst) begin
      hcnt      <= 0;
      out_valid <= 1'b0;
      out_avg   <= '0;
      h0 <= '0; h1 <= '0; h2 <= '0;
    end else begin
      out_valid <= 1'b0;
      if (in_valid) begin
        h2 <= h1; h1 <= h0; h0 <= in_sample;
        hcnt <= hcnt + 1;
        if (hcnt >= 3 && avg_en) begin
          out_valid <= 1'b1;
          out_avg   <= (in_sample + h0 + h1 + h2) >> 2;
        end
      end
    end
  end

  // Strobe / done monitor
  int               strobe_cyc [128];
  logic [WIDTH-1:0] strobe_val [128];
  int               n_strobe = 0;
  int               n_done   = 0;
  always @(negedge clk) begin
    if (!rst) begin
      if (in_valid) begin
        strobe_cyc[n_strobe & 127] = cyc;
        strobe_val[n_strobe & 127] = in_sample;
        n_strobe = n_strobe + 1;
      end
      if (done) n_done = n_done + 1;
    end
  end

  task automatic pulse_start(output int c0);
    @(negedge clk);
    start = 1'b1;
    c0 = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_strobes(input int k);
    int seen = 0;
    int i = 0;
    while (seen < k && i < 300) begin
      @(negedge clk);
      if (in_valid === 1'b1) seen++;
      i++;
    end
    if (seen < k) begin
      n_cmp++; n_fail++;
      $display("FAIL wait_strobes: saw %0d strobes, want %0d", seen, k);
    end
  endtask

  task automatic wait_done(output int dc);
    dc = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        dc = cyc;
        break;
      end
    end
    if (dc < 0) begin
      n_cmp++; n_fail++;
      $display("FAIL wait_done: no done pulse within 300 cycles");
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b want 0", busy); end
    n_cmp++; if (win_rst !== 1'b0) begin n_fail++; $display("FAIL reset_win_rst: got %0b want 0", win_rst); end
    n_cmp++; if (in_valid !== 1'b0) begin n_fail++; $display("FAIL reset_in_valid: got %0b want 0", in_valid); end
    n_cmp++; if (in_sample !== 32'd0) begin n_fail++; $display("FAIL reset_in_sample: got %0d want 0", in_sample); end
    n_cmp++; if (avg_hold !== 32'd0) begin n_fail++; $display("FAIL reset_avg_hold: got %0d want 0", avg_hold); end
    n_cmp++; if (out_count !== 8'd0) begin n_fail++; $display("FAIL reset_out_count: got %0d want 0", out_count); end
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %0b want 0", done); end
    n_cmp++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %0b want 0", timeout); end
    n_cmp++; if (rom_addr !== 3'd0) begin n_fail++; $display("FAIL reset_rom_addr: got %0d want 0", rom_addr); end
  endtask

  task automatic test_nominal;
    int c0, dc, s0, d0, gap;
    s0 = n_strobe; d0 = n_done;
    pulse_start(c0);
    // cycle c0+1: first CLEAR cycle
    n_cmp++; if (win_rst !== 1'b1) begin n_fail++; $display("FAIL nom_clear1_win_rst: got %0b want 1", win_rst); end
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL nom_clear1_busy: got %0b want 1", busy); end
    @(negedge clk);
    n_cmp++; if (win_rst !== 1'b1) begin n_fail++; $display("FAIL nom_clear2_win_rst: got %0b want 1", win_rst); end
    @(negedge clk);
    n_cmp++; if (win_rst !== 1'b0) begin n_fail++; $display("FAIL nom_run_win_rst: got %0b want 0", win_rst); end
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL nom_run_busy: got %0b want 1", busy); end
    wait_done(dc);
    n_cmp++; if (dc - c0 !== 34) begin n_fail++; $display("FAIL nom_done_time: got %0d want 34", dc - c0); end
    n_cmp++; if (out_count !== 8'd4) begin n_fail++; $display("FAIL nom_out_count: got %0d want 4", out_count); end
    n_cmp++; if (avg_hold !== 32'd6) begin n_fail++; $display("FAIL nom_avg_hold: got %0d want 6", avg_hold); end
    n_cmp++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL nom_timeout: got %0b want 0", timeout); end
    @(negedge clk);
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL nom_done_width: got %0b want 0", done); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL nom_idle_busy: got %0b want 0", busy); end
    repeat (4) @(negedge clk);
    n_cmp++; if (n_done - d0 !== 1) begin n_fail++; $display("FAIL nom_done_count: got %0d want 1", n_done - d0); end
    n_cmp++; if (n_strobe - s0 !== 7) begin n_fail++; $display("FAIL nom_strobes: got %0d want 7", n_strobe - s0); end
    gap = strobe_cyc[s0 & 127] - c0;
    n_cmp++; if (gap !== 7) begin n_fail++; $display("FAIL nom_first_strobe: got %0d want 7", gap); end
    for (int k = 0; k < 7; k++) begin
      n_cmp++;
      if (strobe_val[(s0 + k) & 127] !== 32'(k + 2)) begin
        n_fail++;
        $display("FAIL nom_sample%0d: got %0d want %0d", k, strobe_val[(s0 + k) & 127], k + 2);
      end
      if (k > 0) begin
        gap = strobe_cyc[(s0 + k) & 127] - strobe_cyc[(s0 + k - 1) & 127];
        n_cmp++; if (gap !== 4) begin n_fail++; $display("FAIL nom_gap%0d: got %0d want 4", k, gap); end
      end
    end
  endtask

  task automatic test_pause;
    int c0, dc, s0, gap;
    s0 = n_strobe;
    pulse_start(c0);
    wait_strobes(2);
    pause = 1'b1;
    repeat (10) @(negedge clk);
    pause = 1'b0;
    n_cmp++; if (in_sample !== 32'd3) begin n_fail++; $display("FAIL pause_hold_sample: got %0d want 3", in_sample); end
    n_cmp++; if (in_valid !== 1'b0) begin n_fail++; $display("FAIL pause_in_valid: got %0b want 0", in_valid); end
    wait_done(dc);
    n_cmp++; if (dc - c0 !== 44) begin n_fail++; $display("FAIL pause_done_time: got %0d want 44", dc - c0); end
    repeat (3) @(negedge clk);
    gap = strobe_cyc[(s0 + 1) & 127] - strobe_cyc[s0 & 127];
    n_cmp++; if (gap !== 4) begin n_fail++; $display("FAIL pause_gap1: got %0d want 4", gap); end
    gap = strobe_cyc[(s0 + 2) & 127] - strobe_cyc[(s0 + 1) & 127];
    n_cmp++; if (gap !== 14) begin n_fail++; $display("FAIL pause_gap2: got %0d want 14", gap); end
    gap = strobe_cyc[(s0 + 3) & 127] - strobe_cyc[(s0 + 2) & 127];
    n_cmp++; if (gap !== 4) begin n_fail++; $display("FAIL pause_gap3: got %0d want 4", gap); end
    n_cmp++; if (strobe_val[(s0 + 2) & 127] !== 32'd4) begin n_fail++; $display("FAIL pause_sample2: got %0d want 4", strobe_val[(s0 + 2) & 127]); end
    n_cmp++; if (strobe_val[(s0 + 6) & 127] !== 32'd8) begin n_fail++; $display("FAIL pause_sample6: got %0d want 8", strobe_val[(s0 + 6) & 127]); end
  endtask

  task automatic test_abort;
    int c0, dc, s0, d0;
    s0 = n_strobe; d0 = n_done;
    pulse_start(c0);
    wait_strobes(3);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %0b want 0", busy); end
    n_cmp++; if (win_rst !== 1'b1) begin n_fail++; $display("FAIL abort_win_rst: got %0b want 1", win_rst); end
    n_cmp++; if (in_valid !== 1'b0) begin n_fail++; $display("FAIL abort_in_valid: got %0b want 0", in_valid); end
    @(negedge clk);
    n_cmp++; if (win_rst !== 1'b0) begin n_fail++; $display("FAIL abort_win_rst_len: got %0b want 0", win_rst); end
    repeat (40) @(negedge clk);
    n_cmp++; if (n_done - d0 !== 0) begin n_fail++; $display("FAIL abort_no_done: got %0d want 0", n_done - d0); end
    n_cmp++; if (n_strobe - s0 !== 3) begin n_fail++; $display("FAIL abort_strobes: got %0d want 3", n_strobe - s0); end
    pulse_start(c0);
    wait_strobes(1);
    n_cmp++; if (in_sample !== 32'd2) begin n_fail++; $display("FAIL abort_replay_sample: got %0d want 2", in_sample); end
    n_cmp++; if (out_count !== 8'd0) begin n_fail++; $display("FAIL abort_replay_count: got %0d want 0", out_count); end
    wait_done(dc);
    n_cmp++; if (out_count !== 8'd4) begin n_fail++; $display("FAIL abort_replay_final: got %0d want 4", out_count); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_timeout;
    int c0, dc, s0, gap;
    avg_en = 1'b0;
    s0 = n_strobe;
    pulse_start(c0);
    wait_done(dc);
    n_cmp++; if (timeout !== 1'b1) begin n_fail++; $display("FAIL to_flag: got %0b want 1", timeout); end
    n_cmp++; if (out_count !== 8'd0) begin n_fail++; $display("FAIL to_out_count: got %0d want 0", out_count); end
    gap = dc - strobe_cyc[(s0 + 6) & 127];
    n_cmp++; if (gap !== DRAIN_MAX + 1) begin n_fail++; $display("FAIL to_delay: got %0d want %0d", gap, DRAIN_MAX + 1); end
    repeat (3) @(negedge clk);
    n_cmp++; if (timeout !== 1'b1) begin n_fail++; $display("FAIL to_sticky: got %0b want 1", timeout); end
    avg_en = 1'b1;
  endtask

  task automatic test_start_abort_idle;
    int s0;
    s0 = n_strobe;
    @(negedge clk);
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL sa_busy: got %0b want 0", busy); end
    n_cmp++; if (win_rst !== 1'b0) begin n_fail++; $display("FAIL sa_win_rst: got %0b want 0", win_rst); end
    n_cmp++; if (timeout !== 1'b1) begin n_fail++; $display("FAIL sa_timeout_kept: got %0b want 1", timeout); end
    repeat (10) @(negedge clk);
    n_cmp++; if (n_strobe - s0 !== 0) begin n_fail++; $display("FAIL sa_strobes: got %0d want 0", n_strobe - s0); end
  endtask

  task automatic test_start_ignored;
    int c0, dc, s0, d0, gap;
    s0 = n_strobe; d0 = n_done;
    pulse_start(c0);
    @(negedge clk);
    n_cmp++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL si_timeout_clear: got %0b want 0", timeout); end
    start = 1'b1;                  // restart attempt during CLEAR
    @(negedge clk);
    start = 1'b0;
    wait_strobes(1);
    @(negedge clk);
    start = 1'b1;                  // restart attempt during RUN
    @(negedge clk);
    start = 1'b0;
    wait_done(dc);
    n_cmp++; if (dc - c0 !== 34) begin n_fail++; $display("FAIL si_done_time: got %0d want 34", dc - c0); end
    repeat (4) @(negedge clk);
    gap = strobe_cyc[s0 & 127] - c0;
    n_cmp++; if (gap !== 7) begin n_fail++; $display("FAIL si_first_strobe: got %0d want 7", gap); end
    n_cmp++; if (n_strobe - s0 !== 7) begin n_fail++; $display("FAIL si_strobes: got %0d want 7", n_strobe - s0); end
    n_cmp++; if (n_done - d0 !== 1) begin n_fail++; $display("FAIL si_done_count: got %0d want 1", n_done - d0); end
  endtask

  task automatic test_rst_drain;
    int c0, d0;
    d0 = n_done;
    pulse_start(c0);
    wait_strobes(7);               // first DRAIN cycle
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rd_busy: got %0b want 1", busy); end
    n_cmp++; if (out_count !== 8'd3) begin n_fail++; $display("FAIL rd_pre_count: got %0d want 3", out_count); end
    n_cmp++; if (avg_hold !== 32'd5) begin n_fail++; $display("FAIL rd_pre_avg: got %0d want 5", avg_hold); end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rd_busy_rst: got %0b want 0", busy); end
    n_cmp++; if (in_valid !== 1'b0) begin n_fail++; $display("FAIL rd_in_valid: got %0b want 0", in_valid); end
    n_cmp++; if (in_sample !== 32'd0) begin n_fail++; $display("FAIL rd_in_sample: got %0d want 0", in_sample); end
    n_cmp++; if (avg_hold !== 32'd0) begin n_fail++; $display("FAIL rd_avg_hold: got %0d want 0", avg_hold); end
    n_cmp++; if (out_count !== 8'd0) begin n_fail++; $display("FAIL rd_out_count: got %0d want 0", out_count); end
    n_cmp++; if (rom_addr !== 3'd0) begin n_fail++; $display("FAIL rd_rom_addr: got %0d want 0", rom_addr); end
    n_cmp++; if (win_rst !== 1'b0) begin n_fail++; $display("FAIL rd_win_rst: got %0b want 0", win_rst); end
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL rd_done: got %0b want 0", done); end
    rst = 1'b0;
    repeat (25) @(negedge clk);
    n_cmp++; if (n_done - d0 !== 0) begin n_fail++; $display("FAIL rd_no_done: got %0d want 0", n_done - d0); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rd_idle: got %0b want 0", busy); end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_pause();
    test_abort();
    test_timeout();
    test_start_abort_idle();
    test_start_ignored();
    test_rst_drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within 200000 time units");
    $fatal(1);
  end

endmodule
